// File: rtl/ysyx_23060025_icache_pkg.sv
// Shared AXI constants and controller state encoding for the instruction cache.
package ysyx_23060025_icache_pkg;

    localparam logic [1:0] AXI_ADDR_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_ADDR_SIZE_4     = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY       = 2'b00;

    typedef enum logic [2:0] {
        ICACHE_IDLE    = 3'd0,
        ICACHE_LOOKUP  = 3'd1,
        ICACHE_MISS_AR = 3'd2,
        ICACHE_MISS_R  = 3'd3,
        ICACHE_RESP    = 3'd4
    } icache_state_e;

endpackage

// File: rtl/ysyx_23060025_icache_array.sv
// Data and tag storage: one synchronous write port, one asynchronous read port.
module ysyx_23060025_icache_array #(
    parameter int unsigned DATA_LEN   = 32,
    parameter int unsigned SET_NUM    = 16,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned IDX_W      = 4,
    parameter int unsigned OFF_W      = 2,
    parameter int unsigned TAG_W      = 24
) (
    input  logic                clock,
    input  logic                we,
    input  logic                tag_we,
    input  logic [IDX_W-1:0]    w_index,
    input  logic [OFF_W-1:0]    w_offset,
    input  logic [DATA_LEN-1:0] w_data,
    input  logic [TAG_W-1:0]    w_tag,
    input  logic [IDX_W-1:0]    r_index,
    input  logic [OFF_W-1:0]    r_offset,
    output logic [DATA_LEN-1:0] r_data,
    output logic [TAG_W-1:0]    r_tag
);

    logic [DATA_LEN-1:0] data_q [SET_NUM][LINE_WORDS];
    logic [TAG_W-1:0]    tag_q  [SET_NUM];

    always_ff @(posedge clock) begin
        if (we) begin
            data_q[w_index][w_offset] <= w_data;
            if (tag_we) begin
                tag_q[w_index] <= w_tag;
            end
        end
    end

    assign r_data = data_q[r_index][r_offset];
    assign r_tag  = tag_q[r_index];

endmodule

// File: rtl/ysyx_23060025_icache.sv
// Direct-mapped read-only instruction cache: one-cycle hits, single INCR-burst refill on miss.
module ysyx_23060025_icache
    import ysyx_23060025_icache_pkg::*;
#(
    parameter int unsigned ADDR_LEN   = 32,
    parameter int unsigned DATA_LEN   = 32,
    parameter int unsigned SET_NUM    = 16,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ifu_req_valid,
    input  logic [ADDR_LEN-1:0] ifu_req_addr,
    output logic                ifu_req_ready,
    output logic                ifu_rsp_valid,
    output logic [DATA_LEN-1:0] ifu_rsp_data,
    output logic                ifu_rsp_err,
    input  logic                ifu_rsp_ready,
    input  logic                fence_i,
    output logic [ADDR_LEN-1:0] inst_addr_r_addr_o,
    output logic                inst_addr_r_valid_o,
    input  logic                inst_addr_r_ready_i,
    output logic [1:0]          inst_addr_r_burst_o,
    output logic [7:0]          inst_addr_rlen_o,
    output logic [2:0]          inst_addr_rsize_o,
    input  logic [DATA_LEN-1:0] inst_r_data_i,
    input  logic [1:0]          inst_r_resp_i,
    input  logic                inst_r_valid_i,
    input  logic                inst_r_last_i,
    output logic                inst_r_ready_o
);

    localparam int unsigned OFF_W      = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W      = $clog2(SET_NUM);
    localparam int unsigned IDX_LSB    = OFF_W + 2;
    localparam int unsigned TAG_LSB    = IDX_LSB + IDX_W;
    localparam int unsigned TAG_W      = ADDR_LEN - TAG_LSB;
    localparam int unsigned LINE_BYTES = LINE_WORDS * 4;
    localparam logic [OFF_W-1:0]    LAST_BEAT = OFF_W'(LINE_WORDS - 1);
    localparam logic [ADDR_LEN-1:0] LINE_MASK = ~ADDR_LEN'(LINE_BYTES - 1);

    icache_state_e       state;
    logic [ADDR_LEN-1:0] req_addr;
    logic [SET_NUM-1:0]  valid;
    logic [OFF_W-1:0]    beat_cnt;
    logic                refill_err;
    logic                draining;
    logic                fence_pend;

    logic [IDX_W-1:0]    req_index, cur_index;
    logic [OFF_W-1:0]    req_offset, cur_offset;
    logic [TAG_W-1:0]    req_tag, cur_tag, rd_tag;
    logic [DATA_LEN-1:0] rd_data;
    logic                lookup_hit, arr_we, arr_tag_we, err_next, line_ok;

    assign inst_addr_r_burst_o = AXI_ADDR_BURST_INCR;
    assign inst_addr_rlen_o    = 8'(LINE_WORDS - 1);
    assign inst_addr_rsize_o   = AXI_ADDR_SIZE_4;

    assign req_index  = ifu_req_addr[IDX_LSB +: IDX_W];
    assign req_offset = ifu_req_addr[2 +: OFF_W];
    assign req_tag    = ifu_req_addr[TAG_LSB +: TAG_W];
    assign cur_index  = req_addr[IDX_LSB +: IDX_W];
    assign cur_offset = req_addr[2 +: OFF_W];
    assign cur_tag    = req_addr[TAG_LSB +: TAG_W];

    // A fence arriving with the request invalidates first, so it forces a miss.
    assign lookup_hit = valid[req_index] && !fence_i && (rd_tag == req_tag);
    assign arr_we     = (state == ICACHE_MISS_R) && inst_r_valid_i && !draining;
    assign arr_tag_we = arr_we && inst_r_last_i && (beat_cnt == LAST_BEAT);
    assign err_next   = refill_err || (inst_r_resp_i != AXI_RESP_OKAY);
    assign line_ok    = (beat_cnt == LAST_BEAT) && !err_next;

    ysyx_23060025_icache_array #(
        .DATA_LEN   (DATA_LEN),
        .SET_NUM    (SET_NUM),
        .LINE_WORDS (LINE_WORDS),
        .IDX_W      (IDX_W),
        .OFF_W      (OFF_W),
        .TAG_W      (TAG_W)
    ) u_array (
        .clock    (clock),
        .we       (arr_we),
        .tag_we   (arr_tag_we),
        .w_index  (cur_index),
        .w_offset (beat_cnt),
        .w_data   (inst_r_data_i),
        .w_tag    (cur_tag),
        .r_index  (req_index),
        .r_offset (req_offset),
        .r_data   (rd_data),
        .r_tag    (rd_tag)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state               <= ICACHE_IDLE;
            req_addr            <= '0;
            valid               <= '0;
            beat_cnt            <= '0;
            refill_err          <= 1'b0;
            draining            <= 1'b0;
            fence_pend          <= 1'b0;
            ifu_req_ready       <= 1'b0;
            ifu_rsp_valid       <= 1'b0;
            ifu_rsp_data        <= '0;
            ifu_rsp_err         <= 1'b0;
            inst_addr_r_addr_o  <= '0;
            inst_addr_r_valid_o <= 1'b0;
            inst_r_ready_o      <= 1'b0;
        end else begin
            case (state)
                ICACHE_IDLE: begin
                    ifu_req_ready <= 1'b1;
                    if (fence_i) valid <= '0;
                    if (ifu_req_valid && ifu_req_ready) begin
                        req_addr      <= ifu_req_addr;
                        ifu_req_ready <= 1'b0;
                        ifu_rsp_valid <= lookup_hit;
                        ifu_rsp_data  <= rd_data;
                        ifu_rsp_err   <= 1'b0;
                        state         <= ICACHE_LOOKUP;
                    end
                end
                // rsp_valid already carries the hit decision made at acceptance.
                ICACHE_LOOKUP: begin
                    if (fence_i) valid <= '0;
                    if (ifu_rsp_valid) begin
                        if (ifu_rsp_ready) begin
                            ifu_rsp_valid <= 1'b0;
                            ifu_req_ready <= 1'b1;
                            state         <= ICACHE_IDLE;
                        end
                    end else begin
                        inst_addr_r_addr_o  <= req_addr & LINE_MASK;
                        inst_addr_r_valid_o <= 1'b1;
                        state               <= ICACHE_MISS_AR;
                    end
                end
                ICACHE_MISS_AR: begin
                    if (fence_i) fence_pend <= 1'b1;
                    if (inst_addr_r_ready_i) begin
                        inst_addr_r_valid_o <= 1'b0;
                        beat_cnt            <= '0;
                        refill_err          <= 1'b0;
                        draining            <= 1'b0;
                        inst_r_ready_o      <= 1'b1;
                        state               <= ICACHE_MISS_R;
                    end
                end
                ICACHE_MISS_R: begin
                    if (fence_i) fence_pend <= 1'b1;
                    if (inst_r_valid_i) begin
                        if (draining) begin
                            if (inst_r_last_i) begin
                                inst_r_ready_o <= 1'b0;
                                ifu_rsp_valid  <= 1'b1;
                                ifu_rsp_err    <= 1'b1;
                                state          <= ICACHE_RESP;
                            end
                        end else begin
                            beat_cnt   <= beat_cnt + OFF_W'(1);
                            refill_err <= err_next;
                            if (beat_cnt == cur_offset) ifu_rsp_data <= inst_r_data_i;
                            if (inst_r_last_i) begin
                                valid[cur_index] <= line_ok;
                                inst_r_ready_o   <= 1'b0;
                                ifu_rsp_valid    <= 1'b1;
                                ifu_rsp_err      <= !line_ok;
                                state            <= ICACHE_RESP;
                            end else if (beat_cnt == LAST_BEAT) begin
                                // Burst overran the line: swallow beats until last.
                                valid[cur_index] <= 1'b0;
                                refill_err       <= 1'b1;
                                draining         <= 1'b1;
                            end
                        end
                    end
                end
                ICACHE_RESP: begin
                    if (fence_i) fence_pend <= 1'b1;
                    if (ifu_rsp_ready) begin
                        ifu_rsp_valid <= 1'b0;
                        ifu_req_ready <= 1'b1;
                        state         <= ICACHE_IDLE;
                        if (fence_pend || fence_i) begin
                            valid      <= '0;
                            fence_pend <= 1'b0;
                        end
                    end
                end
                default: state <= ICACHE_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060025_icache.sv
// Bench for the instruction cache: AXI slave driver plus a line-level cache model.
module tb_ysyx_23060025_icache;

    logic        clock, reset;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err, ifu_rsp_ready, fence_i;
    logic [31:0] ifu_req_addr, ifu_rsp_data;
    logic [31:0] inst_addr_r_addr_o, inst_r_data_i;
    logic        inst_addr_r_valid_o, inst_addr_r_ready_i, inst_r_valid_i, inst_r_last_i, inst_r_ready_o;
    logic [1:0]  inst_addr_r_burst_o, inst_r_resp_i;
    logic [7:0]  inst_addr_rlen_o;
    logic [2:0]  inst_addr_rsize_o;

    int checks = 0;
    int passes = 0;

    typedef struct {
        int ar_wait;
        int rsp_wait;
        int err_beat;
        int mode;        // 0 normal, 1 last too early, 2 last missing
        int fence_beat;
        bit fence_on_req;
    } knobs_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          n_ar;
        logic [31:0] ar_addr;
        int          lat;
    } obs_t;

    typedef struct {
        bit          hit;
        logic [31:0] data;
        bit          known;
        bit          err;
    } pred_t;

    logic [31:0] mem [logic [31:0]];
    bit          m_valid [16];
    logic [23:0] m_tag   [16];

    ysyx_23060025_icache dut (
        .clock               (clock),
        .reset               (reset),
        .ifu_req_valid       (ifu_req_valid),
        .ifu_req_addr        (ifu_req_addr),
        .ifu_req_ready       (ifu_req_ready),
        .ifu_rsp_valid       (ifu_rsp_valid),
        .ifu_rsp_data        (ifu_rsp_data),
        .ifu_rsp_err         (ifu_rsp_err),
        .ifu_rsp_ready       (ifu_rsp_ready),
        .fence_i             (fence_i),
        .inst_addr_r_addr_o  (inst_addr_r_addr_o),
        .inst_addr_r_valid_o (inst_addr_r_valid_o),
        .inst_addr_r_ready_i (inst_addr_r_ready_i),
        .inst_addr_r_burst_o (inst_addr_r_burst_o),
        .inst_addr_rlen_o    (inst_addr_rlen_o),
        .inst_addr_rsize_o   (inst_addr_rsize_o),
        .inst_r_data_i       (inst_r_data_i),
        .inst_r_resp_i       (inst_r_resp_i),
        .inst_r_valid_i      (inst_r_valid_i),
        .inst_r_last_i       (inst_r_last_i),
        .inst_r_ready_o      (inst_r_ready_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a * 32'h0001_0003 + 32'h1357_9BDF;
    endfunction

    function automatic knobs_t kdef();
        knobs_t k;
        k.ar_wait = 0; k.rsp_wait = 0; k.err_beat = -1;
        k.mode = 0; k.fence_beat = -1; k.fence_on_req = 1'b0;
        return k;
    endfunction

    function automatic int nbeats(input int mode);
        return (mode == 1) ? 3 : ((mode == 2) ? 6 : 4);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    // Predicts the outcome of one fetch from line-level cache rules and updates the model.
    task automatic model_fetch(input logic [31:0] a, input knobs_t k, output pred_t p);
        int          idx = int'((a / 16) % 16);
        int          off = int'((a / 4) % 4);
        logic [23:0] t   = 24'(a / 256);
        int          nb  = nbeats(k.mode);
        if (k.fence_on_req) model_clear();
        p.hit   = m_valid[idx] && (m_tag[idx] == t);
        p.data  = mem_rd(a);
        p.known = p.hit || (off < nb);
        p.err   = !p.hit && ((k.mode != 0) || (k.err_beat >= 0 && k.err_beat < nb));
        if (!p.hit) begin
            m_valid[idx] = !p.err;
            m_tag[idx]   = t;
            if (k.fence_beat >= 0 && k.fence_beat < nb) model_clear();
        end
    endtask

    // Drives one fetch through the IFU port and plays the AXI slave for any refill.
    task automatic do_fetch(input logic [31:0] a, input knobs_t k, output obs_t o);
        int cyc = 0;
        bit done = 1'b0;
        int nb;
        o.data = '0; o.err = 1'b0; o.n_ar = 0; o.ar_addr = '0; o.lat = -1;
        while (ifu_req_ready !== 1'b1 && cyc < 50) begin
            @(posedge clock); @(negedge clock); cyc++;
        end
        checks++;
        if (ifu_req_ready !== 1'b1) $display("FAIL req_ready_wait: got %b want 1", ifu_req_ready);
        else passes++;
        ifu_req_valid = 1'b1; ifu_req_addr = a; fence_i = k.fence_on_req;
        @(posedge clock); @(negedge clock);
        ifu_req_valid = 1'b0; fence_i = 1'b0; cyc = 0;
        while (!done && cyc < 100) begin
            if (ifu_rsp_valid === 1'b1) begin
                o.data = ifu_rsp_data; o.err = ifu_rsp_err; o.lat = cyc;
                for (int w = 0; w < k.rsp_wait; w++) begin
                    @(posedge clock); @(negedge clock);
                    checks++;
                    if (ifu_rsp_valid !== 1'b1 || ifu_rsp_data !== o.data || ifu_rsp_err !== o.err)
                        $display("FAIL rsp_hold: got v=%b d=%h e=%b want v=1 d=%h e=%b",
                                 ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err, o.data, o.err);
                    else passes++;
                end
                ifu_rsp_ready = 1'b1;
                @(posedge clock); @(negedge clock);
                ifu_rsp_ready = 1'b0;
                checks++;
                if (ifu_rsp_valid !== 1'b0 || ifu_req_ready !== 1'b1)
                    $display("FAIL rsp_release: got rsp_valid=%b req_ready=%b want 0/1", ifu_rsp_valid, ifu_req_ready);
                else passes++;
                done = 1'b1;
            end else if (inst_addr_r_valid_o === 1'b1) begin
                o.n_ar++;
                o.ar_addr = inst_addr_r_addr_o;
                checks++;
                if ({inst_addr_r_burst_o, inst_addr_rlen_o, inst_addr_rsize_o} !== {2'b01, 8'd3, 3'b010})
                    $display("FAIL ar_attrs: got burst=%b len=%0d size=%b want 01/3/010",
                             inst_addr_r_burst_o, inst_addr_rlen_o, inst_addr_rsize_o);
                else passes++;
                for (int w = 0; w < k.ar_wait; w++) begin
                    @(posedge clock); @(negedge clock);
                    checks++;
                    if (inst_addr_r_valid_o !== 1'b1 || inst_addr_r_addr_o !== o.ar_addr)
                        $display("FAIL ar_hold: got v=%b a=%h want v=1 a=%h", inst_addr_r_valid_o, inst_addr_r_addr_o, o.ar_addr);
                    else passes++;
                end
                inst_addr_r_ready_i = 1'b1;
                @(posedge clock); @(negedge clock);
                inst_addr_r_ready_i = 1'b0;
                nb = nbeats(k.mode);
                for (int b = 0; b < nb; b++) begin
                    checks++;
                    if (inst_r_ready_o !== 1'b1) $display("FAIL r_ready: beat %0d got %b want 1", b, inst_r_ready_o);
                    else passes++;
                    inst_r_valid_i = 1'b1;
                    inst_r_data_i  = (b < 4) ? mem_rd(o.ar_addr + 32'(4 * b)) : (32'hBAD0_0000 | 32'(b));
                    inst_r_resp_i  = (b == k.err_beat) ? 2'b10 : 2'b00;
                    inst_r_last_i  = (b == nb - 1);
                    fence_i        = (b == k.fence_beat);
                    @(posedge clock); @(negedge clock);
                end
                inst_r_valid_i = 1'b0; inst_r_last_i = 1'b0; inst_r_resp_i = 2'b00; fence_i = 1'b0;
                checks++;
                if (ifu_rsp_valid !== 1'b1) $display("FAIL rsp_after_last: got %b want 1", ifu_rsp_valid);
                else passes++;
                cyc = 0;
            end else begin
                @(posedge clock); @(negedge clock); cyc++;
            end
        end
        if (!done) begin
            checks++;
            $display("FAIL fetch_timeout: addr %h got no response want one", a);
        end
    endtask

    task automatic fetch(input logic [31:0] a, input knobs_t k, output obs_t o, output pred_t p);
        model_fetch(a, k, p);
        do_fetch(a, k, o);
    endtask

    task automatic test_reset();
        ifu_req_valid = 0; ifu_req_addr = '0; ifu_rsp_ready = 0; fence_i = 0;
        inst_addr_r_ready_i = 0; inst_r_data_i = '0; inst_r_resp_i = 2'b00; inst_r_valid_i = 0; inst_r_last_i = 0;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({ifu_req_ready, ifu_rsp_valid, ifu_rsp_err, inst_addr_r_valid_o, inst_r_ready_o} !== 5'b0)
            $display("FAIL reset_ctrl: got %b want 00000",
                     {ifu_req_ready, ifu_rsp_valid, ifu_rsp_err, inst_addr_r_valid_o, inst_r_ready_o});
        else passes++;
        checks++;
        if (ifu_rsp_data !== 32'h0 || inst_addr_r_addr_o !== 32'h0)
            $display("FAIL reset_data: got d=%h a=%h want 0/0", ifu_rsp_data, inst_addr_r_addr_o);
        else passes++;
        checks++;
        if ({inst_addr_r_burst_o, inst_addr_rlen_o, inst_addr_rsize_o} !== {2'b01, 8'd3, 3'b010})
            $display("FAIL reset_consts: got %b want 01/00000011/010",
                     {inst_addr_r_burst_o, inst_addr_rlen_o, inst_addr_rsize_o});
        else passes++;
        reset = 1'b1;
        @(posedge clock); @(negedge clock);
        checks++;
        if (ifu_req_ready !== 1'b1) $display("FAIL reset_release: req_ready got %b want 1", ifu_req_ready);
        else passes++;
        model_clear();
    endtask

    task automatic test_cold_miss();
        obs_t o; pred_t p;
        mem[32'h3000_0000] = 32'h11; mem[32'h3000_0004] = 32'h22;
        mem[32'h3000_0008] = 32'h33; mem[32'h3000_000C] = 32'h44;
        fetch(32'h3000_0004, kdef(), o, p);
        checks++;
        if (o.n_ar !== 1 || o.ar_addr !== 32'h3000_0000)
            $display("FAIL cold_ar: got n=%0d a=%h want 1/30000000", o.n_ar, o.ar_addr);
        else passes++;
        checks++;
        if (o.data !== 32'h22 || o.err !== 1'b0)
            $display("FAIL cold_rsp: got d=%h e=%b want 00000022/0", o.data, o.err);
        else passes++;
    endtask

    task automatic test_hit();
        obs_t o; pred_t p;
        fetch(32'h3000_000C, kdef(), o, p);
        checks++;
        if (o.n_ar !== 0 || o.lat !== 0)
            $display("FAIL hit_timing: got n_ar=%0d lat=%0d want 0/0", o.n_ar, o.lat);
        else passes++;
        checks++;
        if (o.data !== 32'h44 || o.err !== 1'b0)
            $display("FAIL hit_rsp: got d=%h e=%b want 00000044/0", o.data, o.err);
        else passes++;
    endtask

    task automatic test_conflict();
        obs_t o; pred_t p;
        fetch(32'h3000_0104, kdef(), o, p);
        checks++;
        if (o.n_ar !== 1 || o.ar_addr !== 32'h3000_0100 || o.data !== mem_rd(32'h3000_0104))
            $display("FAIL conflict_fill: got n=%0d a=%h d=%h want 1/30000100/%h",
                     o.n_ar, o.ar_addr, o.data, mem_rd(32'h3000_0104));
        else passes++;
        fetch(32'h3000_0004, kdef(), o, p);
        checks++;
        if (o.n_ar !== 1 || o.data !== 32'h22)
            $display("FAIL conflict_evict: got n=%0d d=%h want 1/00000022", o.n_ar, o.data);
        else passes++;
    endtask

    task automatic test_error_beat();
        obs_t o; pred_t p; knobs_t k = kdef();
        k.err_beat = 2;
        fetch(32'h3000_0020, k, o, p);
        checks++;
        if (o.n_ar !== 1 || o.err !== 1'b1) $display("FAIL err_beat: got n=%0d e=%b want 1/1", o.n_ar, o.err);
        else passes++;
        fetch(32'h3000_0020, kdef(), o, p);
        checks++;
        if (o.n_ar !== 1 || o.err !== 1'b0 || o.data !== mem_rd(32'h3000_0020))
            $display("FAIL err_retry: got n=%0d e=%b d=%h want 1/0/%h", o.n_ar, o.err, o.data, mem_rd(32'h3000_0020));
        else passes++;
    endtask

    task automatic test_backpressure();
        obs_t o; pred_t p; knobs_t k = kdef();
        k.ar_wait = 5; k.rsp_wait = 3;
        fetch(32'h3000_0048, k, o, p);
        checks++;
        if (o.n_ar !== 1 || o.ar_addr !== 32'h3000_0040 || o.data !== mem_rd(32'h3000_0048) || o.err !== 1'b0)
            $display("FAIL backpressure: got n=%0d a=%h d=%h e=%b want 1/30000040/%h/0",
                     o.n_ar, o.ar_addr, o.data, o.err, mem_rd(32'h3000_0048));
        else passes++;
    endtask

    task automatic test_fence();
        obs_t o; pred_t p; knobs_t k = kdef();
        k.fence_beat = 1;
        fetch(32'h3000_0080, k, o, p);
        checks++;
        if (o.n_ar !== 1 || o.err !== 1'b0 || o.data !== mem_rd(32'h3000_0080))
            $display("FAIL fence_fill: got n=%0d e=%b d=%h want 1/0/%h", o.n_ar, o.err, o.data, mem_rd(32'h3000_0080));
        else passes++;
        fetch(32'h3000_0080, kdef(), o, p);
        checks++;
        if (o.n_ar !== 1) $display("FAIL fence_pending: got n_ar=%0d want 1", o.n_ar);
        else passes++;
        k = kdef();
        k.fence_on_req = 1'b1;
        fetch(32'h3000_0080, k, o, p);
        checks++;
        if (o.n_ar !== 1) $display("FAIL fence_with_req: got n_ar=%0d want 1", o.n_ar);
        else passes++;
    endtask

    task automatic test_bad_last();
        obs_t o; pred_t p; knobs_t k = kdef();
        k.mode = 1;
        fetch(32'h3000_0090, k, o, p);
        checks++;
        if (o.err !== 1'b1 || o.data !== mem_rd(32'h3000_0090))
            $display("FAIL early_last: got e=%b d=%h want 1/%h", o.err, o.data, mem_rd(32'h3000_0090));
        else passes++;
        fetch(32'h3000_0090, kdef(), o, p);
        checks++;
        if (o.n_ar !== 1 || o.err !== 1'b0) $display("FAIL early_last_retry: got n=%0d e=%b want 1/0", o.n_ar, o.err);
        else passes++;
        k.mode = 2;
        fetch(32'h3000_00A8, k, o, p);
        checks++;
        if (o.err !== 1'b1 || o.data !== mem_rd(32'h3000_00A8))
            $display("FAIL missing_last: got e=%b d=%h want 1/%h", o.err, o.data, mem_rd(32'h3000_00A8));
        else passes++;
        fetch(32'h3000_00A8, kdef(), o, p);
        checks++;
        if (o.n_ar !== 1 || o.err !== 1'b0) $display("FAIL missing_last_retry: got n=%0d e=%b want 1/0", o.n_ar, o.err);
        else passes++;
    endtask

    task automatic test_reset_mid_burst();
        obs_t o; pred_t p;
        int w = 0;
        fetch(32'h3000_00B0, kdef(), o, p);
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h3000_0200;
        @(posedge clock); @(negedge clock);
        ifu_req_valid = 1'b0;
        while (inst_addr_r_valid_o !== 1'b1 && w < 10) begin
            @(posedge clock); @(negedge clock); w++;
        end
        checks++;
        if (inst_addr_r_valid_o !== 1'b1) $display("FAIL mid_ar: got %b want 1", inst_addr_r_valid_o);
        else passes++;
        inst_addr_r_ready_i = 1'b1;
        @(posedge clock); @(negedge clock);
        inst_addr_r_ready_i = 1'b0;
        inst_r_valid_i = 1'b1; inst_r_data_i = 32'h5555_AAAA;
        @(posedge clock); @(negedge clock);
        inst_r_valid_i = 1'b0;
        reset = 1'b0;
        @(posedge clock); @(negedge clock);
        checks++;
        if ({ifu_req_ready, inst_r_ready_o, inst_addr_r_valid_o, ifu_rsp_valid} !== 4'b0)
            $display("FAIL mid_reset: got %b want 0000", {ifu_req_ready, inst_r_ready_o, inst_addr_r_valid_o, ifu_rsp_valid});
        else passes++;
        reset = 1'b1;
        @(posedge clock); @(negedge clock);
        checks++;
        if (ifu_req_ready !== 1'b1) $display("FAIL mid_reset_idle: got %b want 1", ifu_req_ready);
        else passes++;
        model_clear();
        fetch(32'h3000_00B0, kdef(), o, p);
        checks++;
        if (o.n_ar !== 1) $display("FAIL mid_reset_inval: got n_ar=%0d want 1", o.n_ar);
        else passes++;
    endtask

    task automatic test_random();
        obs_t o; pred_t p; knobs_t k;
        logic [31:0] a;
        for (int i = 0; i < 60; i++) begin
            k = kdef();
            a = 32'h3000_0000 + (32'($urandom_range(0, 127)) << 2);
            k.ar_wait  = $urandom_range(0, 3);
            k.rsp_wait = $urandom_range(0, 2);
            if ($urandom_range(0, 7) == 0) k.err_beat = $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) k.fence_beat = $urandom_range(0, 3);
            k.fence_on_req = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 11))
                0: k.mode = 1;
                1: k.mode = 2;
                default: k.mode = 0;
            endcase
            fetch(a, k, o, p);
            checks++;
            if (o.n_ar !== (p.hit ? 0 : 1) || (p.hit && o.lat !== 0) || (!p.hit && o.ar_addr !== (a & ~32'hF)))
                $display("FAIL rand_path[%0d]: addr %h got n_ar=%0d lat=%0d ar=%h want hit=%0b ar=%h",
                         i, a, o.n_ar, o.lat, o.ar_addr, p.hit, a & ~32'hF);
            else passes++;
            checks++;
            if (o.err !== p.err || (p.known && o.data !== p.data))
                $display("FAIL rand_rsp[%0d]: addr %h got d=%h e=%b want d=%h e=%b",
                         i, a, o.data, o.err, p.data, p.err);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_error_beat();
        test_backpressure();
        test_fence();
        test_bad_last();
        test_reset_mid_burst();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
